// File: rtl/instr_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue_if
//
// Bundles the two handshake channels of the instruction prefetch queue:
//   - the instruction-memory channel (request out, in-order response back)
//   - the output channel toward the fetch_decode stage register
//
// Handshake semantics (both valid/ready channels):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   The producer may not make a request's payload change while valid is high
//   and ready is low. ready may depend combinationally on valid. The
//   instruction-memory response channel has no ready: a response is taken in
//   the cycle its valid is high, and responses return in request order.
//
// Modports:
//   master - the prefetch queue (issues imem requests, presents out_*)
//   slave  - the environment (instruction memory plus fetch_decode consumer)
// ----------------------------------------------------------------------------
interface instr_prefetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        output out_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Fetch-side front end. Generates sequential word-aligned fetch addresses,
// issues them to instruction memory, buffers returned words together with
// their PC in a small FIFO and presents the head to fetch_decode. A redirect
// flushes the FIFO, restarts fetch at the new target and discards the
// responses of requests that were still in flight.
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous, active-low reset
//   redirect_valid flush and restart fetch at redirect_pc
//   redirect_pc    new fetch address (bits [1:0] forced to 0)
//   bus            instr_prefetch_queue_if.master (imem request/response and
//                  output channel toward fetch_decode)
//   occupancy      number of entries currently held in the FIFO
//
// Parameters:
//   DEPTH           FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING max imem requests in flight (1..DEPTH)
//   RESET_PC        first fetch address after reset
//
// Configuration macro:
//   PREFETCH_BYPASS_EN - when defined, a response arriving while the FIFO is
//   empty (no redirect, nothing left to drop) is presented on out_* in the
//   same cycle; if it is accepted it never enters the FIFO. When undefined,
//   every word goes through FIFO storage (one cycle response-to-out latency).
// ----------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    instr_prefetch_queue_if.master    bus,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] DEPTH_U   = DEPTH;
    localparam logic [31:0] MAX_OUT_U = MAX_OUTSTANDING;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc;
    logic          req_en;        // keeps requests off until the first edge after reset
    logic [OW-1:0] outstanding;   // accepted requests whose response has not arrived
    logic [OW-1:0] drop_cnt;      // in-flight responses that belong to a flushed stream
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] tag_wr;
    logic [TW-1:0] tag_rd;

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   tag_pc  [MAX_OUTSTANDING];  // addresses of live accepted requests

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        rsp_fire;
    logic        rsp_keep;
    logic        req_valid;
    logic        req_fire;
    logic        head_valid;
    logic        bypass;
    logic        push;
    logic        pop_q;
    logic        out_valid_c;
    logic [31:0] rsp_pc;
    logic [31:0] credit_used;
    logic [31:0] sel_instr;
    logic [31:0] sel_pc;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        if ({{(32-TW){1'b0}}, p} == MAX_OUT_U - 32'd1) begin
            return '0;
        end
        return p + TW'(1);
    endfunction

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = bus.imem_rsp_valid && (outstanding != '0);
    // Responses are dropped during a redirect and while stale ones remain.
    assign rsp_keep = rsp_fire && !redirect_valid && (drop_cnt == '0);
    assign rsp_pc   = tag_pc[tag_rd];

    // Credits: every entry held plus every live (non-dropped) request in
    // flight reserves a FIFO slot, so a kept response always has room.
    assign credit_used = 32'(count) + 32'(outstanding) - 32'(drop_cnt);
    assign req_valid   = req_en && !redirect_valid &&
                         (32'(outstanding) < MAX_OUT_U) &&
                         (credit_used < DEPTH_U);
    assign req_fire    = req_valid && bus.imem_req_ready;

    assign head_valid  = (count != '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass      = rsp_keep && !head_valid;
    assign out_valid_c = !redirect_valid && (head_valid || bypass);
    assign sel_instr   = head_valid ? q_instr[rd_ptr] : bus.imem_rsp_data;
    assign sel_pc      = head_valid ? q_pc[rd_ptr]    : rsp_pc;
    assign push        = rsp_keep && !(bypass && bus.out_ready);
`else
    assign bypass      = 1'b0;
    assign out_valid_c = !redirect_valid && head_valid;
    assign sel_instr   = q_instr[rd_ptr];
    assign sel_pc      = q_pc[rd_ptr];
    assign push        = rsp_keep;
`endif

    // Storage pop only; a bypassed word is consumed without touching storage.
    assign pop_q = out_valid_c && bus.out_ready && head_valid && !bypass;

    // ------------------------------------------------------------------
    // Outputs (payload forced to zero whenever nothing is presented)
    // ------------------------------------------------------------------
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = out_valid_c;
    assign bus.out_instr      = out_valid_c ? sel_instr : 32'h0;
    assign bus.out_pc         = out_valid_c ? sel_pc : 32'h0;
    assign bus.out_pc_plus4   = out_valid_c ? (sel_pc + 32'd4) : 32'h0;
    assign occupancy          = count;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            req_en      <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            req_en <= 1'b1;
            if (redirect_valid) begin
                // No request can be accepted this cycle, so everything still
                // in flight after this cycle's response belongs to the old stream.
                fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
                outstanding <= outstanding - OW'(rsp_fire);
                drop_cnt    <= outstanding - OW'(rsp_fire);
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                tag_wr      <= '0;
                tag_rd      <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_wr   <= tag_next(tag_wr);
                end
                outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
                if (rsp_keep) begin
                    tag_rd <= tag_next(tag_rd);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_q) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + (AW+1)'(push) - (AW+1)'(pop_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Data storage (contents are don't-care until written)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (push) begin
            q_instr[wr_ptr] <= bus.imem_rsp_data;
            q_pc[wr_ptr]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Bench for instr_prefetch_queue (DEPTH=4, MAX_OUTSTANDING=2, RESET_PC=0x100).
// A behavioural instruction memory answers accepted requests in order after a
// configurable latency with a word derived from the address. Every accepted
// request pushes its expected PC to exp_q; every word taken from out_* pops
// exp_q and is compared. A redirect empties exp_q and retargets the expected
// fetch address.
// ----------------------------------------------------------------------------
module tb_instr_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic [$clog2(DEPTH):0] occupancy;

    instr_prefetch_queue_if bus();

    instr_prefetch_queue #(
        .DEPTH          (DEPTH),
        .MAX_OUTSTANDING(MAX_OUT),
        .RESET_PC       (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus),
        .occupancy     (occupancy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc;
    int          last_due;
    logic [31:0] exp_addr;
    int          rdy_pct;
    int          ordy_pct;
    int          lat_min;
    int          lat_max;
    int          n_acc;
    int          n_pop;
    bit          want_first;
    logic [31:0] exp_first;
    bit          saw_wrap;
    int          probe_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        pend_addr.delete();
        pend_due.delete();
        last_due   = 0;
        exp_addr   = RESET_PC;
        want_first = 1'b0;
        cyc        = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.out_ready      = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_pc_plus4", bus.out_pc_plus4, 32'h0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs after the falling edge, sample outputs
    // 1 time unit later, update the model for what the next rising edge commits.
    task automatic step(input bit redir, input logic [31:0] rpc);
        int          lat;
        int          due;
        bit          rsp_now;
        logic [31:0] pc;
        @(negedge clk);
        cyc++;
        redirect_valid     = redir;
        redirect_pc        = rpc;
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus.out_ready      = ($urandom_range(99) < ordy_pct);
        rsp_now = (pend_due.size() > 0) && (pend_due[0] <= cyc);
        if (rsp_now) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
        #1;
        check("occ_range", 32'(occupancy <= DEPTH), 32'h1);
        if (redir) begin
            check("redir_quiet", {30'h0, bus.imem_req_valid, bus.out_valid}, 32'h0);
        end
        // first-response latency probe
        if (probe_state == 1 && rsp_now) begin
`ifdef PREFETCH_BYPASS_EN
            check("lat_rsp_cycle", 32'(bus.out_valid), 32'h1);
            probe_state = 0;
`else
            check("lat_rsp_cycle", 32'(bus.out_valid), 32'h0);
            probe_state = 2;
`endif
        end else if (probe_state == 2) begin
            check("lat_next_cycle", 32'(bus.out_valid), 32'h1);
            probe_state = 0;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_addr);
            exp_q.push_back(exp_addr);
            lat = $urandom_range(lat_max, lat_min);
            due = (last_due + 1 > cyc + lat) ? last_due + 1 : cyc + lat;
            pend_addr.push_back(exp_addr);
            pend_due.push_back(due);
            last_due = due;
            exp_addr = exp_addr + 32'd4;
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready && !redir) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("pop_nonempty", 32'(exp_q.size()), 32'h1);
            end else begin
                pc = exp_q.pop_front();
                check("out_pc", bus.out_pc, pc);
                check("out_instr", bus.out_instr, instr_of(pc));
                check("out_pc_plus4", bus.out_pc_plus4, pc + 32'd4);
                if (want_first) begin
                    check("first_pc", bus.out_pc, exp_first);
                    want_first = 1'b0;
                end
                if (pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            end
        end
        if (redir) begin
            exp_q.delete();
            exp_addr   = rpc & 32'hFFFF_FFFC;
            exp_first  = rpc & 32'hFFFF_FFFC;
            want_first = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  acc0;
        int  pop0;
        bit  found;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.out_ready      = 1'b0;
        n_acc = 0; n_pop = 0; saw_wrap = 1'b0; probe_state = 0;
        rdy_pct = 100; ordy_pct = 100; lat_min = 1; lat_max = 1;
        model_clear();

        // sequential stream, 1-cycle memory, always ready
        do_reset();
        probe_state = 1;
        run(10);
        pop0 = n_pop;
        run(10);
        check("back_to_back", 32'(n_pop - pop0), 32'd10);

        // consumer stalled: exactly DEPTH words buffered, then drain
        do_reset();
        ordy_pct = 0;
        acc0 = n_acc;
        run(10);
        check("stall_accepts", 32'(n_acc - acc0), 32'd4);
        check("stall_occupancy", 32'(occupancy), 32'd4);
        check("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("stall_out_valid", 32'(bus.out_valid), 32'h1);
        ordy_pct = 100;
        run(12);

        // two requests in flight when redirected
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1'b1, 32'h0000_0200);
        acc0 = n_acc;
        run(2);
        check("inflight_two", 32'(n_acc - acc0), 32'd2);
        step(1'b1, 32'h0000_0400);
        run(12);

        // redirect in the same cycle as a response with another outstanding
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend_due.size() >= 2 && pend_due[0] == cyc + 1) begin
                step(1'b1, 32'h0000_0600);
                found = 1'b1;
            end else begin
                step(1'b0, 32'h0);
            end
        end
        check("coincide_setup", 32'(found), 32'h1);
        run(12);

        // unaligned redirect target
        lat_min = 1; lat_max = 1;
        step(1'b1, 32'h0000_0403);
        run(10);

        // address wrap at 2^32
        saw_wrap = 1'b0;
        step(1'b1, 32'hFFFF_FFF8);
        run(12);
        check("wrap_seen", 32'(saw_wrap), 32'h1);

        // random traffic with occasional redirects
        rdy_pct = 70; ordy_pct = 60; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 4) step(1'b1, $urandom());
            else                        step(1'b0, 32'h0);
        end

        // throughput recovers once everything is ready again
        rdy_pct = 100; ordy_pct = 100; lat_min = 1; lat_max = 1;
        run(10);
        pop0 = n_pop;
        run(10);
        check("final_throughput", 32'(n_pop - pop0), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch-side front end that feeds the fetch_decode stage register.
- Generates sequential fetch addresses, issues them to an instruction memory over a valid/ready request channel, and accepts in-order responses.
- Buffers fetched words with their PC and PC+4 in a small FIFO.
- On a redirect (taken branch/jump resolved in execute), flushes the buffer and discards stale in-flight responses.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
MAX_OUTSTANDING, 2, max imem requests in flight (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
imem_req_valid  out  1  request present
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response word valid (in request order, ≥1 cycle after accept)
imem_rsp_data  in  32  instruction word
out_valid  out  1  head entry valid toward fetch_decode
out_ready  in  1  fetch_decode accepts head
out_instr  out  32  head instruction
out_pc  out  32  head PC
out_pc_plus4  out  32  head PC+4 (mod 2^32)
occupancy  out  $clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; imem_req_valid=0; out_valid=0; out_instr/out_pc/out_pc_plus4=0; occupancy=0.
- Issue condition: imem_req_valid = !redirect_valid && outstanding<MAX_OUTSTANDING && (occupancy+outstanding-drop_cnt)<DEPTH. Credit check guarantees no overflow.
- imem_req_addr = fetch_pc. It is held stable while valid && !ready. On accept, fetch_pc += 4 (wraps at 2^32) and outstanding increments.
- Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Otherwise the word is pushed with pc = tag FIFO head (addresses of accepted requests, MAX_OUTSTANDING deep), and pc_plus4 = pc+4.
- Response with outstanding=0 is a protocol error; it is ignored (no push).
- Pop: out_valid && out_ready removes head next edge. Simultaneous push and pop keep occupancy unchanged. A pop and push on a full queue cannot occur because of credit accounting.
- Redirect has priority over all other events in its cycle:
  - queue cleared;
  - out_valid forced 0 combinationally (no pop happens);
  - fetch_pc = {redirect_pc[31:2],2'b00};
  - drop_cnt = outstanding after this cycle's response has been counted. Because imem_req_valid=0 during redirect, no new request is accepted that cycle.
  - A response arriving in the redirect cycle is dropped and is not added to drop_cnt.
  - Back-to-back redirects: the latest wins; drop_cnt is recomputed each time.
- First request after redirect is issued in the following cycle, even while drop_cnt>0, provided credits allow.
- Latency (macro off): request accept at cycle t, response at t+k; out_valid rises at t+k+1.
- occupancy is registered and updated every edge.
- Reset mid-transfer: all state is cleared. Late imem responses after reset release are treated as protocol errors (ignored).

Optional Feature:
PREFETCH_BYPASS_EN
- Defined: when the queue is empty, drop_cnt=0, no redirect, and imem_rsp_valid=1, the response drives out_valid/out_instr/out_pc/out_pc_plus4 combinationally in the same cycle.
  - If out_ready=1 it is consumed without being written to the queue; otherwise it is pushed normally.
  - Response-to-out latency is 0.
- Undefined: all responses go through the queue storage; out_* are driven only from registered entries (latency 1).

Test Plan:
- Reset with RESET_PC=32'h0000_0100, imem_req_ready=1, 1-cycle imem, out_ready=1 → imem_req_addr sequence 0x100,0x104,0x108…; out_pc 0x100,0x104… back-to-back; out_pc_plus4=out_pc+4.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 words buffered; occupancy=4; imem_req_valid=0 once credits exhausted. Release out_ready → 4 entries drain in order, then fetching resumes at 0x110.
- Two requests in flight (0x200, 0x204), redirect_valid=1 with redirect_pc=0x400 before either response → both responses dropped; next out_pc=0x400.
- Redirect cycle coincides with response for 0x204 while 0x208 is outstanding → 0x204 dropped, drop_cnt=1, 0x208 dropped, first delivered out_pc=redirect target.
- redirect_pc=0x0000_0403 → imem_req_addr=0x0000_0400; out_pc=0x400.
- fetch_pc=0xFFFF_FFFC → next imem_req_addr=0x0000_0000; out_pc_plus4 for 0xFFFF_FFFC = 0x0000_0000. With PREFETCH_BYPASS_EN defined, on an empty queue the response appears on out_instr in the same cycle.
